// File: rtl/store_buffer_pkg.sv
// Shared types and helpers for the store buffer and its FIFO.
package sb_pkg;

  localparam int SB_AW = 64;
  localparam int SB_DW = 64;
  localparam int DW_BYTES = 8;
  localparam logic [7:0] MASK_FULL = 8'hFF;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    REQ  = 1'b1
  } drain_state_e;

  typedef struct packed {
    logic [SB_AW-1:0] addr;
    logic [SB_DW-1:0] data;
  } entry_t;

  // Clear the byte offset so the address names a whole doubleword.
  function automatic logic [SB_AW-1:0] dw_align(input logic [SB_AW-1:0] a);
    return {a[SB_AW-1:3], 3'b000};
  endfunction

  // Two byte addresses fall in the same doubleword.
  function automatic logic dw_match(input logic [SB_AW-1:0] a, input logic [SB_AW-1:0] b);
    return (a[SB_AW-1:3] == b[SB_AW-1:3]);
  endfunction

endpackage

// File: rtl/store_buffer_if.sv
// Core-store, memory-write and load-lookup signals of the store buffer.
interface sb_if #(
  parameter int DEPTH = 4,
  parameter int AW    = 64,
  parameter int DW    = 64
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          st_valid;
  logic [AW-1:0] st_addr;
  logic [DW-1:0] st_data;
  logic          st_ready;
  logic          misalign_err;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [7:0]    mem_wmask;
  logic          mem_ack;
  logic [AW-1:0] ld_addr;
  logic          ld_hit;
  logic [DW-1:0] ld_data;
  logic          empty;
  logic [CW-1:0] count;

  // Store buffer side.
  modport slave (
    input  st_valid, st_addr, st_data, mem_ack, ld_addr,
    output st_ready, misalign_err, mem_req, mem_addr, mem_wdata, mem_wmask,
           ld_hit, ld_data, empty, count
  );

  // Core / memory / environment side.
  modport master (
    output st_valid, st_addr, st_data, mem_ack, ld_addr,
    input  st_ready, misalign_err, mem_req, mem_addr, mem_wdata, mem_wmask,
           ld_hit, ld_data, empty, count
  );
endinterface

// File: rtl/sb_fifo.sv
// Circular entry storage with head/tail pointers, occupancy count and an
// age-ordered read-out (index 0 = oldest) used by the forwarding search.
module sb_fifo
  import sb_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  entry_t                 push_entry,
  input  logic                   pop,
  output entry_t                 head_entry,
  output entry_t [DEPTH-1:0]     age_entries,
  output logic   [CW-1:0]        count
);

  entry_t [DEPTH-1:0] mem_q, mem_d;
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  // Next-state for storage, pointers and count; pointers wrap naturally.
  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push) begin
      mem_d[tail_q] = push_entry;
      tail_d        = tail_q + PW'(1);
    end else begin
      tail_d = tail_q;
    end
    if (pop) begin
      head_d = head_q + PW'(1);
    end else begin
      head_d = head_q;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers; reset empties the queue and clears every entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Rotate storage so the consumer sees entries oldest first.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      age_entries[i] = mem_q[head_q + PW'(i)];
    end
  end

  assign head_entry = mem_q[head_q];
  assign count      = count_q;

endmodule

// File: rtl/store_buffer.sv
// Store buffer: queues aligned doubleword stores from the core, drains them
// in order to data memory over req/ack, and forwards buffered data to loads.
module store_buffer
  import sb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = SB_AW,
  parameter int DW    = SB_DW,
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input logic clk,
  input logic rst,
  sb_if.slave bus
);

  logic               st_ready_s;
  logic               push_s;
  logic               pop_s;
  entry_t             push_entry_s;
  entry_t             head_entry_s;
  entry_t [DEPTH-1:0] age_s;
  logic [CW-1:0]      count_s;
  logic               ld_hit_s;
  logic [DW-1:0]      ld_data_s;

  drain_state_e  state_q, state_d;
  logic          mem_req_q, mem_req_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          misalign_q, misalign_d;

  sb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push        (push_s),
    .push_entry  (push_entry_s),
    .pop         (pop_s),
    .head_entry  (head_entry_s),
    .age_entries (age_s),
    .count       (count_s)
  );

  // Accept aligned stores while not full; a misaligned one is flagged instead.
  always_comb begin
    st_ready_s        = (count_s != CW'(DEPTH));
    push_s            = bus.st_valid && st_ready_s && (bus.st_addr[2:0] == 3'b000);
    misalign_d        = bus.st_valid && st_ready_s && (bus.st_addr[2:0] != 3'b000);
    push_entry_s.addr = bus.st_addr;
    push_entry_s.data = bus.st_data;
  end

  // Drain FSM: latch the head into the write port, hold until ack, then pop.
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    pop_s       = 1'b0;
    case (state_q)
      IDLE: begin
        if (count_s != {CW{1'b0}}) begin
          mem_addr_d  = dw_align(head_entry_s.addr);
          mem_wdata_d = head_entry_s.data;
          mem_req_d   = 1'b1;
          state_d     = REQ;
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (bus.mem_ack) begin
          pop_s     = 1'b1;
          mem_req_d = 1'b0;
          state_d   = IDLE;
        end else begin
          state_d = REQ;
        end
      end
      default: begin
        mem_req_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  // Drain FSM and output registers; reset abandons any in-flight write.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      misalign_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      misalign_q  <= misalign_d;
    end
  end

  // Forwarding: scan oldest to youngest so the youngest match wins.
  always_comb begin
    ld_hit_s  = 1'b0;
    ld_data_s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      logic m;
      m         = (CW'(i) < count_s) && dw_match(age_s[i].addr, bus.ld_addr);
      ld_hit_s  = ld_hit_s | m;
      ld_data_s = m ? age_s[i].data : ld_data_s;
    end
  end

  assign bus.st_ready     = st_ready_s;
  assign bus.misalign_err = misalign_q;
  assign bus.mem_req      = mem_req_q;
  assign bus.mem_addr     = mem_addr_q;
  assign bus.mem_wdata    = mem_wdata_q;
  assign bus.mem_wmask    = MASK_FULL;
  assign bus.ld_hit       = ld_hit_s;
  assign bus.ld_data      = ld_data_s;
  assign bus.empty        = (count_s == {CW{1'b0}});
  assign bus.count        = count_s;

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios plus a randomized
// run against a queue-based reference model.
module tb_store_buffer;
  import sb_pkg::*;

  localparam int DEPTH = 4;
  localparam int AW = 64;
  localparam int DW = 64;
  localparam int CW = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sb_if #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) bus();
  store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct { logic [63:0] a; logic [63:0] d; } ment_t;
  ment_t       mq[$];
  bit          m_req;
  logic [63:0] m_addr, m_wdata;
  bit          m_mis;

  // One clock: model reacts to the inputs present before the edge.
  task automatic tick();
    bit ready, push, mis, ack, r;
    ment_t e;
    ready = (mq.size() != DEPTH);
    push  = bus.st_valid && ready && (bus.st_addr[2:0] == 3'b000);
    mis   = bus.st_valid && ready && (bus.st_addr[2:0] != 3'b000);
    e.a = bus.st_addr; e.d = bus.st_data;
    ack = bus.mem_ack; r = rst;
    @(posedge clk);
    if (r) begin
      mq.delete(); m_req = 0; m_addr = '0; m_wdata = '0; m_mis = 0;
    end else begin
      m_mis = mis;
      if (!m_req) begin
        if (mq.size() > 0) begin
          m_req = 1; m_addr = {mq[0].a[63:3], 3'b000}; m_wdata = mq[0].d;
        end
      end else if (ack) begin
        mq.delete(0); m_req = 0;
      end
      if (push) mq.push_back(e);
    end
    #1;
  endtask

  function automatic void model_fwd(input logic [63:0] a, output bit hit, output logic [63:0] d);
    hit = 0; d = '0;
    foreach (mq[i]) if (mq[i].a[63:3] == a[63:3]) begin hit = 1; d = mq[i].d; end
  endfunction

  task automatic test_reset();
    rst = 1'b1; tick(); tick(); rst = 1'b0; #1;
    n_cmp++; if (bus.count !== 3'd0) begin n_bad++; $display("FAIL reset_count got %0d want 0", bus.count); end
    n_cmp++; if (bus.empty !== 1'b1) begin n_bad++; $display("FAIL reset_empty got %b want 1", bus.empty); end
    n_cmp++; if (bus.st_ready !== 1'b1) begin n_bad++; $display("FAIL reset_st_ready got %b want 1", bus.st_ready); end
    n_cmp++; if (bus.mem_req !== 1'b0) begin n_bad++; $display("FAIL reset_mem_req got %b want 0", bus.mem_req); end
    n_cmp++; if (bus.mem_addr !== 64'd0 || bus.mem_wdata !== 64'd0) begin n_bad++; $display("FAIL reset_mem_bus got %h/%h want 0/0", bus.mem_addr, bus.mem_wdata); end
    n_cmp++; if (bus.misalign_err !== 1'b0) begin n_bad++; $display("FAIL reset_misalign got %b want 0", bus.misalign_err); end
    n_cmp++; if (bus.ld_hit !== 1'b0 || bus.ld_data !== 64'd0) begin n_bad++; $display("FAIL reset_fwd got %b/%h want 0/0", bus.ld_hit, bus.ld_data); end
  endtask

  task automatic test_single_store();
    bus.mem_ack = 1'b1; bus.st_valid = 1'b1;
    bus.st_addr = 64'h8000_0008; bus.st_data = 64'h1122_3344_5566_7788;
    tick(); bus.st_valid = 1'b0;
    n_cmp++; if (bus.count !== 3'd1 || bus.mem_req !== 1'b0) begin n_bad++; $display("FAIL single_c1 got cnt=%0d req=%b want 1/0", bus.count, bus.mem_req); end
    tick();
    n_cmp++; if (bus.mem_req !== 1'b1) begin n_bad++; $display("FAIL single_req got %b want 1", bus.mem_req); end
    n_cmp++; if (bus.mem_addr !== 64'h8000_0008 || bus.mem_wdata !== 64'h1122_3344_5566_7788) begin n_bad++; $display("FAIL single_bus got %h/%h want 80000008/1122334455667788", bus.mem_addr, bus.mem_wdata); end
    n_cmp++; if (bus.mem_wmask !== 8'hFF) begin n_bad++; $display("FAIL single_mask got %h want ff", bus.mem_wmask); end
    tick();
    n_cmp++; if (bus.mem_req !== 1'b0 || bus.empty !== 1'b1) begin n_bad++; $display("FAIL single_pop got req=%b empty=%b want 0/1", bus.mem_req, bus.empty); end
  endtask

  task automatic test_fill_and_drain();
    bus.mem_ack = 1'b0;
    for (int k = 0; k < 5; k++) begin
      bus.st_valid = 1'b1; bus.st_addr = 64'h8000_0000 + 64'(8 * k); bus.st_data = 64'(k + 1); #1;
      if (k == 4) begin
        n_cmp++; if (bus.st_ready !== 1'b0) begin n_bad++; $display("FAIL fill_ready got %b want 0", bus.st_ready); end
      end
      tick();
    end
    bus.st_valid = 1'b0;
    n_cmp++; if (bus.count !== 3'd4) begin n_bad++; $display("FAIL fill_count got %0d want 4", bus.count); end
    for (int c = 0; c < 3; c++) begin
      n_cmp++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 64'h8000_0000) begin n_bad++; $display("FAIL fill_hold got req=%b addr=%h want 1/80000000", bus.mem_req, bus.mem_addr); end
      tick();
    end
    bus.mem_ack = 1'b1;
    for (int c = 0; c < 8; c++) begin
      n_cmp++;
      if (bus.mem_req !== ((c % 2) == 0)) begin n_bad++; $display("FAIL drain_req c=%0d got %b want %b", c, bus.mem_req, (c % 2) == 0); end
      else if ((c % 2) == 0 && (bus.mem_addr !== 64'h8000_0000 + 64'(8 * (c / 2)) || bus.mem_wdata !== 64'(c / 2 + 1)))
        begin n_bad++; $display("FAIL drain_order c=%0d got %h/%h", c, bus.mem_addr, bus.mem_wdata); end
      tick();
    end
    n_cmp++; if (bus.empty !== 1'b1) begin n_bad++; $display("FAIL drain_empty got %b want 1", bus.empty); end
  endtask

  task automatic test_misalign();
    bus.mem_ack = 1'b0; bus.st_valid = 1'b1; bus.st_addr = 64'h8000_0004; bus.st_data = 64'hDEAD;
    tick(); bus.st_valid = 1'b0;
    n_cmp++; if (bus.misalign_err !== 1'b1 || bus.count !== 3'd0) begin n_bad++; $display("FAIL mis_pulse got err=%b cnt=%0d want 1/0", bus.misalign_err, bus.count); end
    tick();
    n_cmp++; if (bus.misalign_err !== 1'b0) begin n_bad++; $display("FAIL mis_clear got %b want 0", bus.misalign_err); end
    for (int c = 0; c < 3; c++) begin
      n_cmp++; if (bus.mem_req !== 1'b0) begin n_bad++; $display("FAIL mis_noreq got %b want 0", bus.mem_req); end
      tick();
    end
  endtask

  task automatic test_forwarding();
    bus.mem_ack = 1'b0; bus.ld_addr = 64'h8000_0010;
    bus.st_valid = 1'b1; bus.st_addr = 64'h8000_0010; bus.st_data = 64'd1; #1;
    n_cmp++; if (bus.ld_hit !== 1'b0) begin n_bad++; $display("FAIL fwd_sameclk got %b want 0", bus.ld_hit); end
    tick();
    bus.st_data = 64'd2; tick(); bus.st_valid = 1'b0;
    bus.ld_addr = 64'h8000_0013; #1;
    n_cmp++; if (bus.ld_hit !== 1'b1 || bus.ld_data !== 64'd2) begin n_bad++; $display("FAIL fwd_young got %b/%h want 1/2", bus.ld_hit, bus.ld_data); end
    bus.ld_addr = 64'h8000_0018; #1;
    n_cmp++; if (bus.ld_hit !== 1'b0 || bus.ld_data !== 64'd0) begin n_bad++; $display("FAIL fwd_miss got %b/%h want 0/0", bus.ld_hit, bus.ld_data); end
    bus.mem_ack = 1'b1;
    for (int c = 0; c < 6; c++) tick();
    n_cmp++; if (bus.empty !== 1'b1) begin n_bad++; $display("FAIL fwd_drain got %b want 1", bus.empty); end
  endtask

  task automatic test_full_push_pop();
    bus.mem_ack = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bus.st_valid = 1'b1; bus.st_addr = 64'h9000_0000 + 64'(8 * k); bus.st_data = 64'(k + 16); tick();
    end
    n_cmp++; if (bus.count !== 3'd4 || bus.mem_req !== 1'b1) begin n_bad++; $display("FAIL full_setup got cnt=%0d req=%b want 4/1", bus.count, bus.mem_req); end
    bus.mem_ack = 1'b1; bus.st_addr = 64'h9000_0020; bus.st_data = 64'h55; #1;
    n_cmp++; if (bus.st_ready !== 1'b0) begin n_bad++; $display("FAIL full_ready got %b want 0", bus.st_ready); end
    tick();
    n_cmp++; if (bus.count !== 3'd3) begin n_bad++; $display("FAIL full_pop got %0d want 3", bus.count); end
    bus.mem_ack = 1'b0;
    n_cmp++; if (bus.st_ready !== 1'b1) begin n_bad++; $display("FAIL full_ready2 got %b want 1", bus.st_ready); end
    tick(); bus.st_valid = 1'b0;
    n_cmp++; if (bus.count !== 3'd4) begin n_bad++; $display("FAIL full_repush got %0d want 4", bus.count); end
    bus.mem_ack = 1'b1;
    for (int c = 0; c < 10; c++) tick();
    n_cmp++; if (bus.empty !== 1'b1) begin n_bad++; $display("FAIL full_drain got %b want 1", bus.empty); end
  endtask

  task automatic test_reset_in_req();
    bus.mem_ack = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus.st_valid = 1'b1; bus.st_addr = 64'hA000_0000 + 64'(8 * k); bus.st_data = 64'(k + 32); tick();
    end
    bus.st_valid = 1'b0; bus.ld_addr = 64'hA000_0008;
    n_cmp++; if (bus.count !== 3'd3 || bus.mem_req !== 1'b1) begin n_bad++; $display("FAIL rreq_setup got cnt=%0d req=%b want 3/1", bus.count, bus.mem_req); end
    rst = 1'b1; tick(); rst = 1'b0; #1;
    n_cmp++; if (bus.mem_req !== 1'b0 || bus.count !== 3'd0 || bus.empty !== 1'b1) begin n_bad++; $display("FAIL rreq_state got req=%b cnt=%0d empty=%b want 0/0/1", bus.mem_req, bus.count, bus.empty); end
    n_cmp++; if (bus.st_ready !== 1'b1 || bus.ld_hit !== 1'b0) begin n_bad++; $display("FAIL rreq_io got ready=%b hit=%b want 1/0", bus.st_ready, bus.ld_hit); end
  endtask

  task automatic test_random();
    bit hit; logic [63:0] d;
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      bus.st_valid = $urandom_range(0, 1);
      bus.st_addr = 64'h8000_0000 + 64'(8 * $urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) bus.st_addr = bus.st_addr + 64'($urandom_range(1, 7));
      bus.st_data = {32'($urandom), 32'($urandom)};
      bus.mem_ack = ($urandom_range(0, 2) != 0);
      bus.ld_addr = 64'h8000_0000 + 64'($urandom_range(0, 71));
      #1;
      model_fwd(bus.ld_addr, hit, d);
      n_cmp++; if (bus.st_ready !== (mq.size() != DEPTH)) begin n_bad++; $display("FAIL rnd_ready c=%0d got %b", c, bus.st_ready); end
      n_cmp++; if (bus.ld_hit !== hit || bus.ld_data !== d) begin n_bad++; $display("FAIL rnd_fwd c=%0d got %b/%h want %b/%h", c, bus.ld_hit, bus.ld_data, hit, d); end
      tick();
      n_cmp++; if (bus.count !== CW'(mq.size()) || bus.empty !== (mq.size() == 0)) begin n_bad++; $display("FAIL rnd_count c=%0d got %0d/%b want %0d", c, bus.count, bus.empty, mq.size()); end
      n_cmp++; if (bus.mem_req !== m_req || bus.mem_addr !== m_addr || bus.mem_wdata !== m_wdata) begin n_bad++; $display("FAIL rnd_mem c=%0d got %b/%h/%h want %b/%h/%h", c, bus.mem_req, bus.mem_addr, bus.mem_wdata, m_req, m_addr, m_wdata); end
      n_cmp++; if (bus.misalign_err !== m_mis) begin n_bad++; $display("FAIL rnd_mis c=%0d got %b want %b", c, bus.misalign_err, m_mis); end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; bus.st_valid = 1'b0; bus.st_addr = '0; bus.st_data = '0;
    bus.mem_ack = 1'b0; bus.ld_addr = '0;
    test_reset();
    test_single_store();
    test_fill_and_drain();
    test_misalign();
    test_forwarding();
    test_full_push_pop();
    test_reset_in_req();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1);
  end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Sits directly downstream of the single-cycle RV64 core.
- Consumes the core's store outputs (`memwrite`, `address`, `data`) and queues doubleword stores in a small FIFO.
- Drains the queue to the data-memory port with a req/ack handshake, so a slow memory does not stall every store.
- Provides store-to-load forwarding and a full/stall indication back to the core.

Parameters:
- DEPTH, 4, number of FIFO entries; must be a power of 2, minimum 2.
- AW, 64, address width.
- DW, 64, data width (one doubleword per entry).

Ports:
- clk  input  1  core clock.
- rst  input  1  synchronous, active-high reset.
- st_valid  input  1  store request from the core (core `memwrite`).
- st_addr  input  AW  store byte address (core `address`).
- st_data  input  DW  store data (core `data`).
- st_ready  output  1  buffer can accept a store this cycle; the core stalls its pc when `st_valid` && !`st_ready`.
- misalign_err  output  1  one-cycle pulse, registered, for a rejected misaligned store.
- mem_req  output  1  write request to the data memory.
- mem_addr  output  AW  doubleword-aligned write address.
- mem_wdata  output  DW  write data.
- mem_wmask  output  8  byte enables; always 8'hFF.
- mem_ack  input  1  memory accepted the write.
- ld_addr  input  AW  load address lookup.
- ld_hit  output  1  buffered store matches `ld_addr`.
- ld_data  output  DW  forwarded data from the youngest matching entry.
- empty  output  1  no entries held, including none in flight.
- count  output  $clog2(DEPTH)+1  number of entries held.

Behaviour:
- Reset (synchronous, `rst`=1 at a clk edge): clears all entries.
  - Reset values: `count`=0, `empty`=1, `st_ready`=1, `mem_req`=0, `mem_addr`=0, `mem_wdata`=0, `misalign_err`=0, `ld_hit`=0, `ld_data`=0.
  - An in-flight request is abandoned; `mem_req` drops on the reset edge.
- Enqueue:
  - An accepted store writes {`st_addr`, `st_data`} at the tail; `count` increments at the next edge.
  - Condition: `st_valid` && `st_ready` && `st_addr[2:0]`==0.
  - `st_ready` = (`count` != DEPTH), combinational.
  - When full, no enqueue occurs even if a pop happens in the same cycle; `st_ready` stays 0 that cycle.
- Misalignment: `st_valid` && `st_ready` && `st_addr[2:0]`!=0 means no enqueue, and `misalign_err`=1 for exactly the next cycle.
- Drain FSM, states IDLE and REQ:
  - IDLE: if `count`>0, register the head entry into `mem_addr`={addr[AW-1:3],3'b000} and `mem_wdata`, set `mem_req`=1, and go to REQ.
  - REQ: `mem_addr`, `mem_wdata` and `mem_req` are held stable until `mem_ack`.
  - On `mem_ack` in REQ: pop the head (`count` decrements), `mem_req`=0 at the next edge, return to IDLE.
  - This gives one bubble cycle between consecutive writes.
  - `mem_ack` while in IDLE is ignored.
  - The head entry stays in the FIFO, and visible to forwarding, until it is popped.
- Simultaneous push and pop: `count` is unchanged; pointers advance independently and wrap modulo DEPTH.
- Forwarding:
  - `ld_hit` is combinational: 1 if any held entry has addr[AW-1:3]==`ld_addr`[AW-1:3].
  - `ld_data` comes from the youngest such entry, searching tail-1 back to head; it is 0 when there is no hit.
  - A store being enqueued in the same cycle is not visible to forwarding.
- `empty` = (`count`==0).
- Ordering: memory writes are issued strictly in acceptance order.

Decomposition:
- Shared package `sb_pkg`:
  - DW_BYTES=8.
  - MASK_FULL=8'hFF.
  - Drain state enum {IDLE, REQ}.
  - Entry struct {addr, data}.
- One sub-module, `sb_fifo`: storage, head/tail pointers, count, and an entry read-out array for the forwarding search.
- The drain FSM and forwarding mux stay in `store_buffer`.

Test Plan:
- Reset, then `st_valid`=1, addr 0x80000008, data 0x1122334455667788, `mem_ack` tied 1:
  - `mem_req`=1 two cycles after the store, with `mem_addr`=0x80000008, `mem_wdata` as stored, `mem_wmask`=8'hFF.
  - The entry pops on ack; `empty`=1 afterwards.
- `mem_ack`=0, then 5 stores to 0x80000000, +8, +16, +24, +32 with DEPTH=4:
  - `st_ready`=0 after the 4th store; the 5th is not accepted; `count`=4.
  - `mem_req` holds stable with addr 0x80000000.
  - Raising `mem_ack` drains the entries in order with one bubble between writes.
- Store to 0x80000004:
  - `misalign_err` pulses one cycle; `count` stays 0; `mem_req` never asserts.
- `mem_ack`=0, stores A=0x80000010 data 1, then A data 2:
  - `ld_addr`=0x80000013 gives `ld_hit`=1, `ld_data`=2.
  - `ld_addr`=0x80000018 gives `ld_hit`=0, `ld_data`=0.
- Full FIFO with `mem_ack`=1 and `st_valid`=1 in the same cycle:
  - The pop occurs, the push is rejected, and `count` goes 4→3.
  - Next cycle `st_ready`=1 and the push is accepted.
- Assert `rst` while in REQ with 3 entries held:
  - At the next edge `mem_req`=0, `count`=0, `empty`=1, `st_ready`=1, `ld_hit`=0.
